word_mux_rr: RTL and testbench

WORD_MUX_RR -- requirements
Module: word_mux_rr

---
 rtl/word_mux_rr.sv | 110 +++++++++++
 tb/tb_word_mux_rr.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/word_mux_rr.sv
// Word multiplexer with direct-select and round-robin scan modes and a one-deep registered output.
// Defining WORD_MUX_PARITY_EN adds a registered even-parity output, out_par.
module word_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef WORD_MUX_PARITY_EN
  ,
  output logic                      out_par
`endif
);

  logic [WIDTH-1:0]    out_data_reg;
  logic [SEL_W-1:0]    out_chan_reg;
  logic                out_valid_reg;
  logic [SEL_W-1:0]    ptr_reg;
  logic [SEL_W-1:0]    ptr_next;

  logic [CHANNELS-1:0] sel_hit;
  logic                direct_valid;
  logic [SEL_W-1:0]    rr_grant;
  logic                rr_valid;
  logic [SEL_W-1:0]    grant;
  logic                grant_valid;
  logic                take;
  logic                xfer;
  logic [WIDTH-1:0]    word_next;

  // Decoding sel against each channel index keeps out-of-range selects from ever granting.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign sel_hit[gi]  = (sel == SEL_W'(gi));
      assign in_ready[gi] = xfer && (grant == SEL_W'(gi));
    end
  endgenerate

  assign direct_valid = |(sel_hit & in_valid);

  // Scan from ptr upward with wrap; the first valid channel wins.
  always_comb begin
    int idx;
    idx      = 0;
    rr_valid = 1'b0;
    rr_grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!rr_valid && in_valid[idx]) begin
        rr_valid = 1'b1;
        rr_grant = SEL_W'(idx);
      end
    end
  end

  assign grant       = mode ? rr_grant : sel;
  assign grant_valid = mode ? rr_valid : direct_valid;
  assign take        = ~en_n & (~out_valid_reg | out_ready);
  assign xfer        = grant_valid & take & ~rst;
  assign word_next   = in_data[grant*WIDTH +: WIDTH];
  assign ptr_next    = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else if (xfer) begin
      out_data_reg  <= word_next;
      out_chan_reg  <= grant;
      out_valid_reg <= 1'b1;
      if (mode) ptr_reg <= ptr_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_valid = out_valid_reg;

`ifdef WORD_MUX_PARITY_EN
  logic out_par_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_par_reg <= 1'b0;
    end else if (xfer) begin
      out_par_reg <= ^word_next;
    end
  end

  assign out_par = out_par_reg;
`endif

endmodule

// File: tb/tb_word_mux_rr.sv
// Directed bench for word_mux_rr with default parameters; expected output words
// are queued when a transfer is driven and compared after the loading edge.
module tb_word_mux_rr;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      en_n;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;
`ifdef WORD_MUX_PARITY_EN
  logic                      out_par;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [SEL_W-1:0] chan;
    logic [WIDTH-1:0] data;
  } word_t;

  word_t exp_q[$];

  word_mux_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_n      (en_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef WORD_MUX_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [WIDTH-1:0] d);
    in_data[k*WIDTH +: WIDTH] = d;
  endtask

  task automatic push(input int chan, input logic [WIDTH-1:0] data);
    word_t w;
    w.chan = SEL_W'(chan);
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Check in_ready before the edge, clock once, then compare any queued word.
  task automatic tick(input string tag, input logic [CHANNELS-1:0] exp_rdy);
    word_t w;
    #1;
    chk({tag, "/in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk({tag, "/out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "/out_chan"}, 32'(out_chan), 32'(w.chan));
      chk({tag, "/out_data"}, 32'(out_data), 32'(w.data));
      $display("xfer %s chan=%0d data=%02h", tag, out_chan, out_data);
    end else begin
      $display("idle %s out_valid=%0b", tag, out_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    en_n      = 1'b0;
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < CHANNELS; k++) set_ch(k, 8'h10 + 8'(k));

    // Reset state and in_ready suppression while rst is high
    tick("reset", 4'b0000);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/out_data", 32'(out_data), 32'd0);
    chk("reset/out_chan", 32'(out_chan), 32'd0);

    // Direct select of channel 2
    rst      = 1'b0;
    in_valid = 4'b0100;
    set_ch(2, 8'hA5);
    push(2, 8'hA5);
    tick("direct", 4'b0100);

    // Selected channel not valid: no transfer, held word drains
    sel = 2'd3;
    tick("sel3_invalid", 4'b0000);
    chk("sel3_invalid/out_valid", 32'(out_valid), 32'd0);

    // Round-robin over all channels, one word per cycle
    mode     = 1'b1;
    in_valid = 4'b1111;
    set_ch(2, 8'h12);
    for (int i = 0; i < 5; i++) begin
      push(i % 4, 8'h10 + 8'(i % 4));
      tick("rr_full", 4'(1 << (i % 4)));
    end

    // Backpressure holds the word and blocks all channels
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("backpressure", 4'b0000);
      chk("backpressure/out_valid", 32'(out_valid), 32'd1);
      chk("backpressure/out_data", 32'(out_data), 32'h10);
      chk("backpressure/out_chan", 32'(out_chan), 32'd0);
    end
    out_ready = 1'b1;
    push(1, 8'h11);
    tick("bp_release", 4'b0010);

    // Disabled: pending word drains, nothing new loads
    en_n = 1'b1;
    tick("disabled", 4'b0000);
    chk("disabled/out_valid", 32'(out_valid), 32'd0);
    chk("disabled/out_data", 32'(out_data), 32'h11);
    tick("disabled2", 4'b0000);
    chk("disabled2/out_valid", 32'(out_valid), 32'd0);

    // Mode change acts on the same cycle; ptr survives direct-mode transfers
    en_n = 1'b0;
    mode = 1'b0;
    sel  = 2'd0;
    push(0, 8'h10);
    tick("mode_direct", 4'b0001);
    mode = 1'b1;
    push(2, 8'h12);
    tick("mode_rr", 4'b0100);

    // Wrap from channel 3 back to 0, then sparse valids
    in_valid = 4'b0011;
    push(0, 8'h10);
    tick("rr_wrap", 4'b0001);
    in_valid = 4'b0010;
    push(1, 8'h11);
    tick("rr_sparse", 4'b0010);

    // Activity on non-granted channels while the output is held
    out_ready = 1'b0;
    in_valid  = 4'b1001;
    set_ch(0, 8'hEE);
    set_ch(3, 8'h5A);
    tick("non_granted", 4'b0000);
    chk("non_granted/out_data", 32'(out_data), 32'h11);
    chk("non_granted/out_chan", 32'(out_chan), 32'd1);
    chk("non_granted/out_valid", 32'(out_valid), 32'd1);

    // Reset while a word is held discards it and rewinds ptr to 0
    rst = 1'b1;
    tick("rst_hold", 4'b0000);
    chk("rst_hold/out_valid", 32'(out_valid), 32'd0);
    chk("rst_hold/out_data", 32'(out_data), 32'd0);
    chk("rst_hold/out_chan", 32'(out_chan), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    push(0, 8'hEE);
    tick("post_rst_rr", 4'b0001);

    // Parity samples
    mode     = 1'b0;
    sel      = 2'd1;
    in_valid = 4'b0010;
    set_ch(1, 8'h07);
    push(1, 8'h07);
    tick("parity_odd", 4'b0010);
`ifdef WORD_MUX_PARITY_EN
    chk("parity_odd/out_par", 32'(out_par), 32'd1);
`endif
    set_ch(1, 8'h03);
    push(1, 8'h03);
    tick("parity_even", 4'b0010);
`ifdef WORD_MUX_PARITY_EN
    chk("parity_even/out_par", 32'(out_par), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
